control_unit: RTL and testbench
===============================

# control_unit

Moore-style control FSM that sequences the six-instruction 16-bit processor through fetch, decode and execute. It owns the program counter, drives the instruction-register load strobe, and drives the data-memory, register-file and ALU control lines of the datapath. It sits between the instruction memory/instruction register and the datapath; all datapath blocks take their control from it.

## Interface
- PC_WIDTH, 7, program counter / instruction-memory address width
- Clock  in  1  system clock, rising edge
- ResetN  in  1  asynchronous, active-low reset
- IR  in  16  current instruction from the instruction register
- Run  in  1  level; 1 permits fetching
- PC_Addr  out  PC_WIDTH  instruction-memory address
- IR_Ld  out  1  instruction-register load enable
- D_Addr  out  8  data-memory address
- D_Wr  out  1  data-memory write enable
- RF_s  out  1  register-file write mux: 1 = ALU result, 0 = memory data
- RF_W_Addr  out  4  register-file write address
- RF_W_En  out  1  register-file write enable
- RF_Ra_Addr  out  4  read port A address
- RF_Rb_Addr  out  4  read port B address
- ALU_s0  out  3  ALU op: 000 pass, 001 add, 010 sub
- Halted  out  1  high while in HALT
- IllegalOp  out  1  one-cycle pulse in DECODE on an undefined opcode
- StateOut  out  4  state code, for debug

## Operation
- Instruction fields: op = IR[15:12].
  - 0000 NOOP
  - 0001 STORE: Ra = IR[11:8], addr = IR[7:0]
  - 0010 LOAD: addr = IR[11:4], Rd = IR[3:0]
  - 0011 ADD: Ra = IR[11:8], Rb = IR[7:4], Rd = IR[3:0]
  - 0100 SUB: same fields as ADD
  - 0101 HALT
  - 0110–1111 illegal
- States and StateOut codes: INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ADD 7, SUB 8, HALT 9.
- State transitions:
  - INIT → FETCH unconditionally.
  - FETCH with Run = 1 → DECODE. With Run = 0 it stays in FETCH, with IR_Ld = 0 and the PC held.
  - DECODE → the execute state selected by op. Illegal opcodes go to NOOP.
  - LOAD_A → LOAD_B → FETCH.
  - NOOP, STORE, ADD and SUB → FETCH.
  - HALT → HALT until reset.
- Outputs are combinational from state and IR. Any output not listed for a state is 0.
  - FETCH with Run = 1: IR_Ld = 1.
  - LOAD_A: D_Addr = IR[11:4], RF_W_Addr = IR[3:0], RF_s = 0.
  - LOAD_B: same as LOAD_A, plus RF_W_En = 1.
  - STORE: D_Addr = IR[7:0], RF_Ra_Addr = IR[11:8], D_Wr = 1.
  - ADD: RF_Ra_Addr = IR[11:8], RF_Rb_Addr = IR[7:4], RF_W_Addr = IR[3:0], ALU_s0 = 001, RF_s = 1, RF_W_En = 1.
  - SUB: as ADD, but ALU_s0 = 010.
  - HALT: Halted = 1.
- PC_Addr is the registered PC. It increments by 1 on the clock edge that ends a FETCH cycle with Run = 1. It wraps from 2^PC_WIDTH−1 to 0.
- Run is sampled only in FETCH. Dropping Run mid-instruction does not abort the instruction; the FSM stalls at the next FETCH.

## Timing
- Reset:
  - ResetN low forces state INIT and PC = 0 immediately, without waiting for a clock.
  - All outputs read 0 and StateOut = 0 while reset is held.
  - Reset asserted mid-instruction abandons the instruction. No write strobe survives into the reset cycle.
- Instruction latency, counting FETCH:
  - NOOP, STORE, ADD, SUB and illegal opcodes: 3 cycles.
  - LOAD: 4 cycles. LOAD_A allows for the synchronous data-memory read.
  - HALT reaches the HALT state on the 3rd cycle.
- The IR is loaded at the end of FETCH and is valid throughout DECODE and the execute state(s).
- D_Wr and RF_W_En are each high for exactly one cycle per instruction.
- After reset release, the first FETCH is the 2nd cycle and presents PC_Addr = 0.

## Configuration
- Macro: CU_TRAP_ILLEGAL_EN.
- Defined: an illegal opcode drives DECODE → HALT and pulses IllegalOp in DECODE. Halted rises on the next cycle.
- Undefined: an illegal opcode executes as NOOP, and IllegalOp is tied to 0.

## Test plan
- Reset: hold ResetN = 0 with Run = 1, then release → StateOut = 0 for one cycle, then 1. PC_Addr = 0 in that FETCH, IR_Ld = 1, and PC_Addr = 1 in the following DECODE.
- ADD: IR = 16'h3123 → the execute state has StateOut = 7, RF_Ra_Addr = 1, RF_Rb_Addr = 2, RF_W_Addr = 3, ALU_s0 = 001, RF_s = 1, RF_W_En = 1 for one cycle. Next state is FETCH. SUB with IR = 16'h4123 gives the same response with ALU_s0 = 010 and StateOut = 8.
- LOAD: IR = 16'h21B5 → D_Addr = 8'h1B in both LOAD_A and LOAD_B. RF_W_Addr = 5. RF_W_En = 1 only in LOAD_B. Total 4 cycles from FETCH to the next FETCH.
- STORE: IR = 16'h1A40 → D_Addr = 8'h40, RF_Ra_Addr = 4'hA, D_Wr = 1 for exactly one cycle.
- Run stall and wrap: with PC_WIDTH = 7, preload the PC at 127 via a NOOP stream, then drop Run in FETCH → the FSM stays in FETCH with IR_Ld = 0 and PC_Addr = 127. Raising Run → PC_Addr = 0 after the next edge.
- HALT and illegal: IR = 16'h5000 → Halted = 1 and stays 1 for 20 cycles, with PC frozen. IR = 16'h9000:
  - with CU_TRAP_ILLEGAL_EN defined: IllegalOp pulses for one cycle, then Halted = 1.
  - with it undefined: the instruction behaves as NOOP, returning to FETCH.

Source files
------------

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the six-instruction 16-bit processor.
// Optional macro CU_TRAP_ILLEGAL_EN: illegal opcodes trap to HALT instead of running as NOOP.
module control_unit #(
  parameter int PC_WIDTH = 7
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic [15:0]         IR,
  input  logic                Run,
  output logic [PC_WIDTH-1:0] PC_Addr,
  output logic                IR_Ld,
  output logic [7:0]          D_Addr,
  output logic                D_Wr,
  output logic                RF_s,
  output logic [3:0]          RF_W_Addr,
  output logic                RF_W_En,
  output logic [3:0]          RF_Ra_Addr,
  output logic [3:0]          RF_Rb_Addr,
  output logic [2:0]          ALU_s0,
  output logic                Halted,
  output logic                IllegalOp,
  output logic [3:0]          StateOut
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [3:0]          op;

  assign op = IR[15:12];

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state <= S_INIT;
      pc    <= '0;
    end else begin
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH: begin
          if (Run) begin
            state <= S_DECODE;
            pc    <= pc + 1'b1;  // natural wrap at 2^PC_WIDTH
          end
        end
        S_DECODE: begin
          case (op)
            4'h0:    state <= S_NOOP;
            4'h1:    state <= S_STORE;
            4'h2:    state <= S_LOAD_A;
            4'h3:    state <= S_ADD;
            4'h4:    state <= S_SUB;
            4'h5:    state <= S_HALT;
`ifdef CU_TRAP_ILLEGAL_EN
            default: state <= S_HALT;
`else
            default: state <= S_NOOP;
`endif
          endcase
        end
        S_LOAD_A: state <= S_LOAD_B;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  assign PC_Addr  = pc;
  assign StateOut = state;

  always_comb begin
    IR_Ld      = 1'b0;
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_Addr  = '0;
    RF_W_En    = 1'b0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    ALU_s0     = 3'b000;
    Halted     = 1'b0;
    IllegalOp  = 1'b0;
    case (state)
      S_FETCH: IR_Ld = Run;
`ifdef CU_TRAP_ILLEGAL_EN
      S_DECODE: IllegalOp = (op > 4'h5);
`endif
      S_LOAD_A, S_LOAD_B: begin
        D_Addr    = IR[11:4];
        RF_W_Addr = IR[3:0];
        RF_W_En   = (state == S_LOAD_B);  // data-memory read lands one cycle after LOAD_A
      end
      S_STORE: begin
        D_Addr     = IR[7:0];
        RF_Ra_Addr = IR[11:8];
        D_Wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_Addr = IR[11:8];
        RF_Rb_Addr = IR[7:4];
        RF_W_Addr  = IR[3:0];
        ALU_s0     = (state == S_ADD) ? 3'b001 : 3'b010;
        RF_s       = 1'b1;
        RF_W_En    = 1'b1;
      end
      S_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expectations queued by stimulus, checked by a monitor.
module tb_control_unit;

  typedef struct packed {
    logic [3:0] st;
    logic [6:0] pc;
    logic       irld;
    logic [7:0] daddr;
    logic       dwr;
    logic       rfs;
    logic [3:0] wa;
    logic       we;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
    logic       halted;
    logic       ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] ir;
  logic        run;
  logic [6:0]  pc_addr;
  logic        ir_ld, d_wr, rf_s, rf_we, halted, illop;
  logic [7:0]  d_addr;
  logic [3:0]  wa, ra, rb, st;
  logic [2:0]  alu;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  control_unit #(.PC_WIDTH(7)) dut (
    .Clock(clk), .ResetN(rstn), .IR(ir), .Run(run),
    .PC_Addr(pc_addr), .IR_Ld(ir_ld), .D_Addr(d_addr), .D_Wr(d_wr),
    .RF_s(rf_s), .RF_W_Addr(wa), .RF_W_En(rf_we), .RF_Ra_Addr(ra),
    .RF_Rb_Addr(rb), .ALU_s0(alu), .Halted(halted), .IllegalOp(illop),
    .StateOut(st)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are settled mid-cycle, compare against the oldest queued expectation
  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{st, pc_addr, ir_ld, d_addr, d_wr, rf_s, wa, rf_we, ra, rb, alu, halted, illop};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cyc%0d: got st=%0d pc=%0d irld=%b da=%h dwr=%b rfs=%b wa=%h we=%b ra=%h rb=%h alu=%b hlt=%b ill=%b | want st=%0d pc=%0d irld=%b da=%h dwr=%b rfs=%b wa=%h we=%b ra=%h rb=%h alu=%b hlt=%b ill=%b",
                 checks, a.st, a.pc, a.irld, a.daddr, a.dwr, a.rfs, a.wa, a.we, a.ra, a.rb, a.alu, a.halted, a.ill,
                 e.st, e.pc, e.irld, e.daddr, e.dwr, e.rfs, e.wa, e.we, e.ra, e.rb, e.alu, e.halted, e.ill);
      end
    end
  end

  function automatic exp_t mk(input logic [3:0] s, input logic [6:0] p);
    exp_t e;
    e = '0;
    e.st = s;
    e.pc = p;
    return e;
  endfunction

  function automatic exp_t fetch(input logic [6:0] p, input logic r);
    exp_t e;
    e = mk(4'd1, p);
    e.irld = r;
    return e;
  endfunction

  task automatic cyc(input logic [15:0] i, input logic r, input logic rs, input exp_t e);
    ir = i; run = r; rstn = rs;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    logic [6:0] p;
    rstn = 1'b0; run = 1'b1; ir = 16'h0000;
    @(posedge clk); #1;
    // reset held with Run=1
    cyc(16'h0000, 1, 0, mk(4'd0, 7'd0));
    cyc(16'h0000, 1, 0, mk(4'd0, 7'd0));
    cyc(16'h0000, 1, 1, mk(4'd0, 7'd0));  // INIT cycle after release
    // ADD 3123 @ pc 0
    cyc(16'h3123, 1, 1, fetch(7'd0, 1));
    cyc(16'h3123, 1, 1, mk(4'd2, 7'd1));
    e = mk(4'd7, 7'd1); e.ra = 4'd1; e.rb = 4'd2; e.wa = 4'd3; e.alu = 3'b001; e.rfs = 1; e.we = 1;
    cyc(16'h3123, 1, 1, e);
    // SUB 4123 @ pc 1
    cyc(16'h4123, 1, 1, fetch(7'd1, 1));
    cyc(16'h4123, 1, 1, mk(4'd2, 7'd2));
    e = mk(4'd8, 7'd2); e.ra = 4'd1; e.rb = 4'd2; e.wa = 4'd3; e.alu = 3'b010; e.rfs = 1; e.we = 1;
    cyc(16'h4123, 1, 1, e);
    // LOAD 21B5 @ pc 2, Run dropped mid-instruction must not abort it
    cyc(16'h21B5, 1, 1, fetch(7'd2, 1));
    cyc(16'h21B5, 0, 1, mk(4'd2, 7'd3));
    e = mk(4'd4, 7'd3); e.daddr = 8'h1B; e.wa = 4'd5;
    cyc(16'h21B5, 0, 1, e);
    e.st = 4'd5; e.we = 1;
    cyc(16'h21B5, 1, 1, e);
    // STORE 1A40 @ pc 3
    cyc(16'h1A40, 1, 1, fetch(7'd3, 1));
    cyc(16'h1A40, 1, 1, mk(4'd2, 7'd4));
    e = mk(4'd6, 7'd4); e.daddr = 8'h40; e.ra = 4'hA; e.dwr = 1;
    cyc(16'h1A40, 1, 1, e);
    // NOOP stream walks PC from 4 up to 127
    for (int k = 4; k < 127; k++) begin
      p = 7'(k);
      cyc(16'h0000, 1, 1, fetch(p, 1));
      cyc(16'h0000, 1, 1, mk(4'd2, p + 7'd1));
      cyc(16'h0000, 1, 1, mk(4'd3, p + 7'd1));
    end
    // stall at PC 127, then wrap to 0
    for (int k = 0; k < 3; k++) cyc(16'h0000, 0, 1, fetch(7'd127, 0));
    cyc(16'h0000, 1, 1, fetch(7'd127, 1));
    cyc(16'h0000, 1, 1, mk(4'd2, 7'd0));
    cyc(16'h0000, 1, 1, mk(4'd3, 7'd0));
    // illegal opcode 9000 @ pc 0
    cyc(16'h9000, 1, 1, fetch(7'd0, 1));
    e = mk(4'd2, 7'd1);
`ifdef CU_TRAP_ILLEGAL_EN
    e.ill = 1;
    cyc(16'h9000, 1, 1, e);
    e = mk(4'd9, 7'd1); e.halted = 1;
    for (int k = 0; k < 3; k++) cyc(16'h9000, 1, 1, e);
`else
    cyc(16'h9000, 1, 1, e);
    cyc(16'h9000, 1, 1, mk(4'd3, 7'd1));
    cyc(16'h1A40, 1, 1, fetch(7'd1, 1));
    cyc(16'h1A40, 1, 1, mk(4'd2, 7'd2));
`endif
    // reset asserted where a STORE strobe would otherwise appear
    cyc(16'h1A40, 1, 0, mk(4'd0, 7'd0));
    cyc(16'h1A40, 1, 1, mk(4'd0, 7'd0));
    // HALT 5000 @ pc 0, PC frozen while halted
    cyc(16'h5000, 1, 1, fetch(7'd0, 1));
    cyc(16'h5000, 1, 1, mk(4'd2, 7'd1));
    e = mk(4'd9, 7'd1); e.halted = 1;
    for (int k = 0; k < 20; k++) cyc(16'h5000, 1, 1, e);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
